// File: rtl/fpu_add_result_buffer.sv
// Result stage behind the FP32 adder: captures tagged adder results into a small
// first-word-fall-through FIFO and releases them over a valid/ready handshake.
module fpu_add_result_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_W     = 2,
    parameter int unsigned EXC_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          Add_Data,
    input  logic                 Add_Data_Valid,
    input  logic                 In_Data_Valid,
    output logic                 In_Ready,
    output logic [31:0]          Data_Out,
    output logic                 Data_Out_Exc,
    output logic                 Data_Out_Valid,
    input  logic                 Out_Ready,
    input  logic                 Clr_Status,
    output logic                 Overflow,
    output logic [EXC_CNT_W-1:0] Exc_Count,
    output logic [PTR_W:0]       Level
);

    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [32:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [32:0]      head;
    logic             push;
    logic             pop;

    // Full/empty come from Level so that wrapped pointers never alias.
    assign In_Ready       = (Level != FULL_LEVEL);
    assign Data_Out_Valid = (Level != '0);
    assign push           = In_Data_Valid & In_Ready;
    assign pop            = Data_Out_Valid & Out_Ready;
    assign head           = mem[rd_ptr];

    always_comb begin
        Data_Out     = '0;
        Data_Out_Exc = 1'b0;
        if (Data_Out_Valid) begin
            Data_Out     = head[31:0];
            Data_Out_Exc = head[32];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {~Add_Data_Valid, Add_Data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Level     <= '0;
            Overflow  <= 1'b0;
            Exc_Count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop)
                Level <= Level + (PTR_W + 1)'(1);
            else if (pop && !push)
                Level <= Level - (PTR_W + 1)'(1);

            // Clear wins over a same-cycle set or increment.
            if (Clr_Status) begin
                Overflow  <= 1'b0;
                Exc_Count <= '0;
            end else begin
                if (In_Data_Valid && !In_Ready)
                    Overflow <= 1'b1;
                if (push && !Add_Data_Valid && !(&Exc_Count))
                    Exc_Count <= Exc_Count + EXC_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpu_add_result_buffer.sv
// Table-driven bench for fpu_add_result_buffer with a queue scoreboard for the
// data path and hand-written sequences for reset and post-reset corners.
module tb_fpu_add_result_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] Add_Data;
    logic        Add_Data_Valid;
    logic        In_Data_Valid;
    logic        In_Ready;
    logic [31:0] Data_Out;
    logic        Data_Out_Exc;
    logic        Data_Out_Valid;
    logic        Out_Ready;
    logic        Clr_Status;
    logic        Overflow;
    logic [15:0] Exc_Count;
    logic [2:0]  Level;

    fpu_add_result_buffer #(
        .DEPTH    (4),
        .PTR_W    (2),
        .EXC_CNT_W(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Add_Data      (Add_Data),
        .Add_Data_Valid(Add_Data_Valid),
        .In_Data_Valid (In_Data_Valid),
        .In_Ready      (In_Ready),
        .Data_Out      (Data_Out),
        .Data_Out_Exc  (Data_Out_Exc),
        .Data_Out_Valid(Data_Out_Valid),
        .Out_Ready     (Out_Ready),
        .Clr_Status    (Clr_Status),
        .Overflow      (Overflow),
        .Exc_Count     (Exc_Count),
        .Level         (Level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] add_data;
        logic        add_valid;
        logic        out_ready;
        logic        clr;
        logic [2:0]  exp_level;
        logic        exp_ovf;
        logic [15:0] exp_exc;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] sb[$];
    logic [2:0]  m_level;
    int unsigned n_checks;
    int unsigned n_fail;

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic av,
                                input logic orr, input logic clr, input logic [2:0] lvl,
                                input logic ovf, input logic [15:0] exc);
        vec_t v;
        v.in_valid  = iv;
        v.add_data  = d;
        v.add_valid = av;
        v.out_ready = orr;
        v.clr       = clr;
        v.exp_level = lvl;
        v.exp_ovf   = ovf;
        v.exp_exc   = exc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] lvl,
                                 input logic ovf, input logic [15:0] exc);
        check({tag, " level"},     64'(Level), 64'(lvl));
        check({tag, " in_ready"},  64'(In_Ready), 64'(lvl != 3'd4));
        check({tag, " valid"},     64'(Data_Out_Valid), 64'(lvl != 3'd0));
        check({tag, " overflow"},  64'(Overflow), 64'(ovf));
        check({tag, " exc_count"}, 64'(Exc_Count), 64'(exc));
        if (sb.size() != 0) begin
            check({tag, " data"}, 64'(Data_Out), 64'(sb[0][31:0]));
            check({tag, " exc"},  64'(Data_Out_Exc), 64'(sb[0][32]));
        end else begin
            check({tag, " data"}, 64'(Data_Out), 64'd0);
            check({tag, " exc"},  64'(Data_Out_Exc), 64'd0);
        end
    endtask

    task automatic run_step(input string tag, input vec_t v);
        logic was_full;
        logic was_empty;
        @(negedge clk);
        In_Data_Valid  = v.in_valid;
        Add_Data       = v.add_data;
        Add_Data_Valid = v.add_valid;
        Out_Ready      = v.out_ready;
        Clr_Status     = v.clr;
        was_full       = (m_level == 3'd4);
        was_empty      = (m_level == 3'd0);
        @(posedge clk);
        #1;
        if (!was_empty && v.out_ready)
            void'(sb.pop_front());
        if (v.in_valid && !was_full)
            sb.push_back({~v.add_valid, v.add_data});
        m_level = v.exp_level;
        check_outputs(tag, v.exp_level, v.exp_ovf, v.exp_exc);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        m_level        = 3'd0;
        rst_n          = 1'b0;
        Add_Data       = '0;
        Add_Data_Valid = 1'b0;
        In_Data_Valid  = 1'b0;
        Out_Ready      = 1'b0;
        Clr_Status     = 1'b0;

        //         iv   data           av   or   clr  lvl   ovf  exc
        tbl.push_back(mk(1, 32'h3F800000, 1, 0, 0, 3'd1, 0, 16'd0)); // 0 first push
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 3'd0, 0, 16'd0)); // 1 drain
        tbl.push_back(mk(1, 32'h40000000, 1, 0, 0, 3'd1, 0, 16'd0)); // 2 fill
        tbl.push_back(mk(1, 32'h40400000, 1, 0, 0, 3'd2, 0, 16'd0)); // 3
        tbl.push_back(mk(1, 32'h40800000, 1, 0, 0, 3'd3, 0, 16'd0)); // 4
        tbl.push_back(mk(1, 32'h40A00000, 1, 0, 0, 3'd4, 0, 16'd0)); // 5 full
        tbl.push_back(mk(1, 32'h12345678, 1, 0, 0, 3'd4, 1, 16'd0)); // 6 dropped strobe
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 3'd4, 1, 16'd0)); // 7 sticky, head held
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 3'd3, 1, 16'd0)); // 8 drain
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 3'd2, 1, 16'd0)); // 9
        tbl.push_back(mk(1, 32'h40C00000, 1, 1, 0, 3'd2, 1, 16'd0)); // 10 push+pop at 2
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 3'd1, 1, 16'd0)); // 11
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 3'd0, 1, 16'd0)); // 12
        tbl.push_back(mk(1, 32'h00400000, 0, 0, 0, 3'd1, 1, 16'd1)); // 13 exceptional push
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 3'd1, 0, 16'd0)); // 14 clear status
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 3'd0, 0, 16'd0)); // 15
        tbl.push_back(mk(1, 32'h7F800000, 0, 0, 1, 3'd1, 0, 16'd0)); // 16 clear beats incr
        tbl.push_back(mk(0, 32'hDEADBEEF, 0, 0, 0, 3'd1, 0, 16'd0)); // 17 idle junk data
        tbl.push_back(mk(1, 32'h41000000, 1, 0, 0, 3'd2, 0, 16'd0)); // 18
        tbl.push_back(mk(1, 32'h41100000, 1, 0, 0, 3'd3, 0, 16'd0)); // 19
        tbl.push_back(mk(1, 32'h41200000, 1, 0, 0, 3'd4, 0, 16'd0)); // 20 full
        tbl.push_back(mk(1, 32'h41300000, 1, 1, 0, 3'd3, 1, 16'd0)); // 21 full: pop, push refused
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 3'd3, 1, 16'd0)); // 22

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 3'd0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            run_step($sformatf("vec%0d", i), tbl[i]);

        // Asynchronous reset in the middle of a cycle with three entries held.
        @(negedge clk);
        In_Data_Valid = 1'b0;
        Out_Ready     = 1'b0;
        Clr_Status    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_level = 3'd0;
        check_outputs("async_rst", 3'd0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 3'd0, 1'b0, 16'd0);

        run_step("empty_pop",  mk(0, 32'h0,        1, 1, 0, 3'd0, 0, 16'd0));
        run_step("relatency",  mk(1, 32'h3F000000, 1, 0, 0, 3'd1, 0, 16'd0));
        run_step("pushpop_l1", mk(1, 32'h3E800000, 1, 1, 0, 3'd1, 0, 16'd0));
        run_step("final_pop",  mk(0, 32'h0,        1, 1, 0, 3'd0, 0, 16'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
